bus_pattern_gen: RTL



---
 rtl/bus_pattern_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/bus_pattern_gen.sv
// Pattern source and optional readback checker for the shared tri-state data bus.
// Define BUS_PATTERN_CHECK_EN to compile in the checker (err_count/err_flag); otherwise both are tied to 0.
module bus_pattern_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'h5500),
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [2:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drive_en,
    input  logic             check_en,
    inout  wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] pattern,
    output logic [7:0]       err_count,
    output logic             err_flag
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_INC   = 3'd1,
        MODE_DEC   = 3'd2,
        MODE_ROTL  = 3'd3,
        MODE_LFSR  = 3'd4,
        MODE_INV   = 3'd5,
        MODE_HOLD6 = 3'd6,
        MODE_HOLD7 = 3'd7
    } mode_e;

    logic [WIDTH-1:0] r_pattern;
    logic [WIDTH-1:0] w_step_val;
    mode_e            w_mode;

    assign w_mode  = mode_e'(mode);
    assign pattern = r_pattern;
    assign bus     = drive_en ? r_pattern : {WIDTH{1'bz}};

    // NOTE: every variable assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_step_val = r_pattern;
        case (w_mode)
            MODE_INC:  w_step_val = r_pattern + WIDTH'(1);
            MODE_DEC:  w_step_val = r_pattern - WIDTH'(1);
            MODE_ROTL: w_step_val = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
            MODE_LFSR: begin
                // An all-zero Galois LFSR never leaves zero, so kick it to 1.
                if (r_pattern == '0)
                    w_step_val = WIDTH'(1);
                else
                    w_step_val = (r_pattern >> 1) ^ (r_pattern[0] ? LFSR_TAPS : '0);
            end
            MODE_INV:  w_step_val = ~r_pattern;
            default:   w_step_val = r_pattern;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset)
            r_pattern <= SEED;
        else if (load)
            r_pattern <= load_data;
        else if (step)
            r_pattern <= w_step_val;
    end

`ifdef BUS_PATTERN_CHECK_EN
    logic [7:0] r_err_count;
    logic       r_err_flag;
    logic       w_check;
    logic       w_mismatch;

    assign w_check = step & check_en & ~drive_en & ~load;

`ifdef SYNTHESIS
    assign w_mismatch = (bus != r_pattern);
`else
    // Floating or unknown bus bits must read as a mismatch in simulation.
    assign w_mismatch = (bus !== r_pattern);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_count <= 8'd0;
            r_err_flag  <= 1'b0;
        end else if (w_check && w_mismatch) begin
            if (r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
            r_err_flag <= 1'b1;
        end
    end

    assign err_count = r_err_count;
    assign err_flag  = r_err_flag;
`else
    logic w_unused_check_en;

    assign w_unused_check_en = check_en;
    assign err_count         = 8'd0;
    assign err_flag          = 1'b0;
`endif

endmodule
